pzcorebus_request_arbiter: RTL and testbench
============================================

Name: pzcorebus_request_arbiter

Overview:
- Shares one pzcorebus request channel (command + write data) between N requesters.
- Round-robin arbitration on the command channel; the output command is registered.
- Write data is steered in command-grant order via an internal source-ID FIFO, so data bursts never interleave.
- Sits upstream of a request slicer, in front of a shared memory or CSR target.

Parameters:
- SLAVES, 2, number of requester ports (2..16).
- COMMAND_WIDTH, 64, packed command width.
- WRITE_DATA_WIDTH, 64, packed write-data width, excluding last flag.
- ID_FIFO_DEPTH, 4, outstanding write commands whose data is not yet fully forwarded (power of 2, >=2).
- ID_WIDTH, $clog2(SLAVES) (min 1), derived source-ID width.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  synchronous, active-high reset
- i_mcmd_valid  input  SLAVES  per-requester command valid
- o_scmd_accept  output  SLAVES  per-requester command accept
- i_mcmd  input  SLAVES*COMMAND_WIDTH  packed commands
- i_mcmd_is_write  input  SLAVES  command carries write data
- i_mdata_valid  input  SLAVES  per-requester write-data valid
- o_sdata_accept  output  SLAVES  per-requester write-data accept
- i_mdata  input  SLAVES*WRITE_DATA_WIDTH  packed write data
- i_mdata_last  input  SLAVES  final beat of burst
- o_mcmd_valid  output  1  master command valid
- i_scmd_accept  input  1  master command accept
- o_mcmd  output  COMMAND_WIDTH  master command
- o_mdata_valid  output  1  master write-data valid
- i_sdata_accept  input  1  master write-data accept
- o_mdata  output  WRITE_DATA_WIDTH  master write data
- o_mdata_last  output  1  master last flag
- o_grant_id  output  ID_WIDTH  source of the current o_mcmd

Behaviour:
- Reset (i_rst high at clock edge):
  - o_mcmd_valid=0; o_mcmd, o_grant_id = 0.
  - ID FIFO emptied.
  - Round-robin pointer set to 0 (slave 0 highest priority on first arbitration).
  - All accepts and o_mdata_valid are 0 while the FIFO is empty.
  - Reset mid-burst drops in-flight state; no partial beats are forwarded after reset.
- Command output stage:
  - One register; "open" when o_mcmd_valid=0 or i_scmd_accept=1.
- Eligibility of requester i:
  - i_mcmd_valid[i]=1, and
  - either i_mcmd_is_write[i]=0, or the FIFO is not full or being popped this cycle.
- Grant:
  - When the stage is open, the first eligible requester at or after the RR pointer (wrapping) is granted.
  - o_scmd_accept[grant]=1 combinationally; all other command accepts are 0.
  - Next cycle: o_mcmd = i_mcmd[grant], o_grant_id = grant, o_mcmd_valid = 1.
  - RR pointer moves to grant+1 mod SLAVES.
  - Latency: exactly 1 cycle from slave handshake to master valid.
  - Full throughput: 1 command per cycle when i_scmd_accept stays high.
- Held command:
  - Stage not open: o_mcmd, o_grant_id and o_mcmd_valid hold; no accepts are issued.
- ID FIFO push:
  - A granted write command pushes its ID in the grant cycle.
  - Full FIFO blocks only write commands; read commands keep flowing.
- Write data steering:
  - With head ID h: o_mdata_valid = i_mdata_valid[h]; o_mdata and o_mdata_last = slave h's inputs; o_sdata_accept[h] = i_sdata_accept.
  - All other data accepts are 0. FIFO empty: no data moves.
  - Data combinational path, zero latency. Data reaches the master no earlier than the cycle its command appears there.
- ID FIFO pop:
  - Pops on a master data handshake with o_mdata_last=1.
  - Simultaneous push and pop on a full FIFO is allowed; occupancy is unchanged.
- Single-requester and idle cases:
  - SLAVES=1 degenerates to a registered pass-through.
  - Requesters with no valid never affect the RR pointer.

Optional Feature:
- Macro: PZCOREBUS_REQUEST_ARBITER_URGENT_EN.
- Defined:
  - Adds port i_urgent (input, SLAVES).
  - Eligible urgent requesters beat all non-urgent ones; round-robin applies within each class, with a shared pointer.
  - Write-data steering is unaffected.
- Undefined:
  - Port absent; pure round-robin.

Decomposition:
- pzcorebus_pkg gains:
  - function get_arbiter_id_width(SLAVES)
  - typedef pzcorebus_arbiter_id_t sizing helper
- Sub-module pzcorebus_request_arbiter_rr_core:
  - Inputs: request vector, optional urgent vector, advance strobe.
  - Outputs: one-hot grant, binary grant ID.
  - Holds the pointer register.
- ID FIFO reuses the existing pzbcm FIFO.

Test Plan:
- SLAVES=4, all four post reads at once with i_scmd_accept=1 -> grants 0,1,2,3,0 on consecutive cycles; each o_mcmd is one cycle after its accept.
- Slave1 write (4 beats) then slave2 write (2 beats), data offered together -> master sees 4 beats from 1 then 2 from 2, never interleaved; last flag on beats 4 and 6.
- ID_FIFO_DEPTH=2, two writes granted, data withheld -> 3rd write stalls while a slave3 read is granted; first last-beat handshake lets the write through that cycle.
- i_scmd_accept low 5 cycles with o_mcmd_valid=1 -> o_mcmd/o_grant_id stable; zero slave accepts.
- i_rst asserted mid-burst (beat 2 of 4) -> next cycle o_mcmd_valid=0, o_mdata_valid=0, FIFO empty, next grant goes to slave 0.
- URGENT_EN: slaves 0 and 2 valid, i_urgent=4'b0100 -> slave 2 granted first, then slave 0.

Source files
------------

// File: rtl/pzcorebus_request_arbiter_pkg.sv
// rtl/pzcorebus_request_arbiter_pkg.sv - shared sizing helpers for the pzcorebus request arbiter
//
// Contents:
//   get_arbiter_id_width(slaves) : source-ID width for a given requester count (min 1 bit)
//   PZCOREBUS_ARBITER_ID_MAX_WIDTH / pzcorebus_arbiter_id_t : widest source ID (16 requesters)
package pzcorebus_request_arbiter_pkg;

    localparam int PZCOREBUS_ARBITER_ID_MAX_WIDTH = 4;

    typedef logic [PZCOREBUS_ARBITER_ID_MAX_WIDTH-1:0] pzcorebus_arbiter_id_t;

    // A single requester still needs a 1-bit ID so that ports never collapse to zero width.
    function automatic int get_arbiter_id_width(int slaves);
        return (slaves <= 1) ? 1 : $clog2(slaves);
    endfunction

endpackage

// File: rtl/pzcorebus_request_arbiter_rr_core.sv
// rtl/pzcorebus_request_arbiter_rr_core.sv - round-robin grant selection with pointer register
//
// Optional macro: PZCOREBUS_REQUEST_ARBITER_URGENT_EN (adds i_urgent priority class)
//
// Ports:
//   i_clk, i_rst  : clock, synchronous active-high reset (pointer back to 0)
//   i_request     : per-requester eligible request vector
//   i_urgent      : per-requester urgent flag (macro builds only)
//   i_advance     : a grant was taken this cycle; move pointer past it
//   o_grant       : one-hot grant (all zero when nothing requests)
//   o_grant_id    : binary index of o_grant
module pzcorebus_request_arbiter_rr_core
    import pzcorebus_request_arbiter_pkg::*;
#(
    parameter int SLAVES   = 2,
    parameter int ID_WIDTH = get_arbiter_id_width(SLAVES)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [SLAVES-1:0]   i_request,
`ifdef PZCOREBUS_REQUEST_ARBITER_URGENT_EN
    input  logic [SLAVES-1:0]   i_urgent,
`endif
    input  logic                i_advance,
    output logic [SLAVES-1:0]   o_grant,
    output logic [ID_WIDTH-1:0] o_grant_id
);

    logic [ID_WIDTH-1:0] ptr_q;
    logic [ID_WIDTH-1:0] ptr_d;
    logic [SLAVES-1:0]   class_req;
    logic                found;

    // Urgent requesters form their own class; the same pointer is applied inside
    // whichever class wins, so neither class can starve its own members.
`ifdef PZCOREBUS_REQUEST_ARBITER_URGENT_EN
    assign class_req = (|(i_request & i_urgent)) ? (i_request & i_urgent) : i_request;
`else
    assign class_req = i_request;
`endif

    // Two fixed-priority scans instead of a rotate: first the requesters at or
    // above the pointer, then the wrap-around part below it.
    always_comb begin
        found      = 1'b0;
        o_grant    = '0;
        o_grant_id = '0;
        for (int i = 0; i < SLAVES; i++) begin
            if (!found && class_req[i] && (ID_WIDTH'(i) >= ptr_q)) begin
                found      = 1'b1;
                o_grant[i] = 1'b1;
                o_grant_id = ID_WIDTH'(i);
            end
        end
        for (int i = 0; i < SLAVES; i++) begin
            if (!found && class_req[i]) begin
                found      = 1'b1;
                o_grant[i] = 1'b1;
                o_grant_id = ID_WIDTH'(i);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (i_advance && found) begin
            ptr_d = (o_grant_id == ID_WIDTH'(SLAVES - 1)) ? '0 : o_grant_id + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/pzcorebus_request_arbiter.sv
// rtl/pzcorebus_request_arbiter.sv - N:1 pzcorebus request arbiter with grant-ordered write data
//
// Optional macro: PZCOREBUS_REQUEST_ARBITER_URGENT_EN (adds i_urgent input)
//
// Ports:
//   i_clk, i_rst                       : clock, synchronous active-high reset
//   i_mcmd_valid/o_scmd_accept/i_mcmd  : per-requester command channel (packed)
//   i_mcmd_is_write                    : requester command carries a write-data burst
//   i_urgent                           : per-requester urgent flag (macro builds only)
//   i_mdata_valid/o_sdata_accept/i_mdata/i_mdata_last : per-requester write data
//   o_mcmd_valid/i_scmd_accept/o_mcmd  : registered master command
//   o_grant_id                         : requester that issued o_mcmd
//   o_mdata_valid/i_sdata_accept/o_mdata/o_mdata_last : master write data (combinational)
module pzcorebus_request_arbiter
    import pzcorebus_request_arbiter_pkg::*;
#(
    parameter int SLAVES           = 2,
    parameter int COMMAND_WIDTH    = 64,
    parameter int WRITE_DATA_WIDTH = 64,
    parameter int ID_FIFO_DEPTH    = 4,
    parameter int ID_WIDTH         = get_arbiter_id_width(SLAVES)
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic [SLAVES-1:0]                  i_mcmd_valid,
    output logic [SLAVES-1:0]                  o_scmd_accept,
    input  logic [SLAVES*COMMAND_WIDTH-1:0]    i_mcmd,
    input  logic [SLAVES-1:0]                  i_mcmd_is_write,
`ifdef PZCOREBUS_REQUEST_ARBITER_URGENT_EN
    input  logic [SLAVES-1:0]                  i_urgent,
`endif
    input  logic [SLAVES-1:0]                  i_mdata_valid,
    output logic [SLAVES-1:0]                  o_sdata_accept,
    input  logic [SLAVES*WRITE_DATA_WIDTH-1:0] i_mdata,
    input  logic [SLAVES-1:0]                  i_mdata_last,
    output logic                               o_mcmd_valid,
    input  logic                               i_scmd_accept,
    output logic [COMMAND_WIDTH-1:0]           o_mcmd,
    output logic                               o_mdata_valid,
    input  logic                               i_sdata_accept,
    output logic [WRITE_DATA_WIDTH-1:0]        o_mdata,
    output logic                               o_mdata_last,
    output logic [ID_WIDTH-1:0]                o_grant_id
);

    localparam int PTR_W = $clog2(ID_FIFO_DEPTH);

    // ---------------- ID FIFO (grant order of write commands) ----------------
    logic [ID_WIDTH-1:0] fifo_mem_q [ID_FIFO_DEPTH];
    logic [PTR_W:0]      wr_ptr_q;
    logic [PTR_W:0]      wr_ptr_d;
    logic [PTR_W:0]      rd_ptr_q;
    logic [PTR_W:0]      rd_ptr_d;
    logic                fifo_empty;
    logic                fifo_full;
    logic                fifo_push;
    logic                fifo_pop;
    logic [ID_WIDTH-1:0] head_id;

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head_id    = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];

    // ---------------- write data steering ----------------
    logic                        sel_valid;
    logic                        sel_last;
    logic [WRITE_DATA_WIDTH-1:0] sel_data;

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < SLAVES; i++) begin
            if (head_id == ID_WIDTH'(i)) begin
                sel_valid = i_mdata_valid[i];
                sel_last  = i_mdata_last[i];
                sel_data  = i_mdata[i*WRITE_DATA_WIDTH +: WRITE_DATA_WIDTH];
            end
        end
    end

    assign o_mdata_valid = !fifo_empty && sel_valid;
    assign o_mdata_last  = !fifo_empty && sel_last;
    assign o_mdata       = sel_data;

    always_comb begin
        o_sdata_accept = '0;
        for (int i = 0; i < SLAVES; i++) begin
            if (!fifo_empty && (head_id == ID_WIDTH'(i))) begin
                o_sdata_accept[i] = i_sdata_accept;
            end
        end
    end

    assign fifo_pop = o_mdata_valid && i_sdata_accept && o_mdata_last;

    // ---------------- command arbitration ----------------
    logic                     stage_open;
    logic                     write_ok;
    logic [SLAVES-1:0]        eligible;
    logic [SLAVES-1:0]        arb_request;
    logic [SLAVES-1:0]        grant;
    logic [ID_WIDTH-1:0]      grant_id;
    logic                     any_grant;
    logic [COMMAND_WIDTH-1:0] grant_cmd;

    assign stage_open = !o_mcmd_valid || i_scmd_accept;
    // A pop in the same cycle frees the slot a full FIFO would otherwise deny.
    assign write_ok    = !fifo_full || fifo_pop;
    assign eligible    = i_mcmd_valid & ~(i_mcmd_is_write & {SLAVES{!write_ok}});
    assign arb_request = stage_open ? eligible : '0;

    pzcorebus_request_arbiter_rr_core #(
        .SLAVES   (SLAVES),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_core (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_request  (arb_request),
`ifdef PZCOREBUS_REQUEST_ARBITER_URGENT_EN
        .i_urgent   (i_urgent),
`endif
        .i_advance  (any_grant),
        .o_grant    (grant),
        .o_grant_id (grant_id)
    );

    assign any_grant     = |grant;
    assign o_scmd_accept = grant;
    assign fifo_push     = |(grant & i_mcmd_is_write);

    always_comb begin
        grant_cmd = '0;
        for (int i = 0; i < SLAVES; i++) begin
            if (grant[i]) begin
                grant_cmd = i_mcmd[i*COMMAND_WIDTH +: COMMAND_WIDTH];
            end
        end
    end

    // ---------------- command output register ----------------
    logic                     mcmd_valid_q;
    logic                     mcmd_valid_d;
    logic [COMMAND_WIDTH-1:0] mcmd_q;
    logic [COMMAND_WIDTH-1:0] mcmd_d;
    logic [ID_WIDTH-1:0]      grant_id_q;
    logic [ID_WIDTH-1:0]      grant_id_d;

    always_comb begin
        mcmd_valid_d = mcmd_valid_q;
        mcmd_d       = mcmd_q;
        grant_id_d   = grant_id_q;
        if (stage_open) begin
            mcmd_valid_d = any_grant;
            if (any_grant) begin
                mcmd_d     = grant_cmd;
                grant_id_d = grant_id;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mcmd_valid_q <= 1'b0;
            mcmd_q       <= '0;
            grant_id_q   <= '0;
        end else begin
            mcmd_valid_q <= mcmd_valid_d;
            mcmd_q       <= mcmd_d;
            grant_id_q   <= grant_id_d;
        end
    end

    assign o_mcmd_valid = mcmd_valid_q;
    assign o_mcmd       = mcmd_q;
    assign o_grant_id   = grant_id_q;

    // ---------------- FIFO pointer/storage update ----------------
    assign wr_ptr_d = fifo_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = fifo_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (fifo_push) begin
            fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= grant_id;
        end
    end

endmodule

// File: tb/tb_pzcorebus_request_arbiter.sv
// tb/tb_pzcorebus_request_arbiter.sv - self-checking bench for pzcorebus_request_arbiter
module tb_pzcorebus_request_arbiter;

    localparam int N     = 4;
    localparam int CW    = 16;
    localparam int DW    = 16;
    localparam int DEPTH = 2;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic [N-1:0]    mcmd_valid;
    logic [N-1:0]    o_scmd_accept;
    logic [N*CW-1:0] mcmd;
    logic [N-1:0]    is_write;
    logic [N-1:0]    urgent;
    logic [N-1:0]    mdata_valid;
    logic [N-1:0]    o_sdata_accept;
    logic [N*DW-1:0] mdata;
    logic [N-1:0]    mdata_last;
    logic            o_mcmd_valid;
    logic            scmd_accept;
    logic [CW-1:0]   o_mcmd;
    logic            o_mdata_valid;
    logic            sdata_accept;
    logic [DW-1:0]   o_mdata;
    logic            o_mdata_last;
    logic [1:0]      o_grant_id;

    int checks   = 0;
    int failures = 0;

    pzcorebus_request_arbiter #(
        .SLAVES           (N),
        .COMMAND_WIDTH    (CW),
        .WRITE_DATA_WIDTH (DW),
        .ID_FIFO_DEPTH    (DEPTH)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_mcmd_valid    (mcmd_valid),
        .o_scmd_accept   (o_scmd_accept),
        .i_mcmd          (mcmd),
        .i_mcmd_is_write (is_write),
`ifdef PZCOREBUS_REQUEST_ARBITER_URGENT_EN
        .i_urgent        (urgent),
`endif
        .i_mdata_valid   (mdata_valid),
        .o_sdata_accept  (o_sdata_accept),
        .i_mdata         (mdata),
        .i_mdata_last    (mdata_last),
        .o_mcmd_valid    (o_mcmd_valid),
        .i_scmd_accept   (scmd_accept),
        .o_mcmd          (o_mcmd),
        .o_mdata_valid   (o_mdata_valid),
        .i_sdata_accept  (sdata_accept),
        .o_mdata         (o_mdata),
        .o_mdata_last    (o_mdata_last),
        .o_grant_id      (o_grant_id)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        mcmd_valid   = '0;
        mcmd         = '0;
        is_write     = '0;
        urgent       = '0;
        mdata_valid  = '0;
        mdata        = '0;
        mdata_last   = '0;
        scmd_accept  = 1'b1;
        sdata_accept = 1'b1;
    endtask

    task automatic do_reset();
        clear_inputs();
        i_rst = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    task automatic tick();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    // Round-robin choice from the arbitration rules: urgent class first, then scan from rr.
    function automatic int model_pick(logic [N-1:0] elig, logic [N-1:0] urg, int rr);
        logic [N-1:0] cls;
        cls = ((elig & urg) != '0) ? (elig & urg) : elig;
        for (int k = 0; k < N; k++) begin
            if (cls[(rr + k) % N]) return (rr + k) % N;
        end
        return -1;
    endfunction

    task automatic test_reset();
        clear_inputs();
        i_rst       = 1'b1;
        mdata_valid = 4'hF;
        mdata_last  = 4'hF;
        @(posedge i_clk);
        @(negedge i_clk);
        #1;
        checks++;
        if (o_mcmd_valid !== 1'b0) begin failures++; $display("FAIL reset_mcmd_valid got=%b exp=0", o_mcmd_valid); end
        checks++;
        if (o_mcmd !== '0 || o_grant_id !== '0) begin failures++; $display("FAIL reset_mcmd got=%h/%0d exp=0/0", o_mcmd, o_grant_id); end
        checks++;
        if (o_mdata_valid !== 1'b0 || o_sdata_accept !== '0) begin
            failures++; $display("FAIL reset_data got=%b/%b exp=0/0000", o_mdata_valid, o_sdata_accept);
        end
        checks++;
        if (o_scmd_accept !== '0) begin failures++; $display("FAIL reset_accept got=%b exp=0000", o_scmd_accept); end
        i_rst = 1'b0;
        clear_inputs();
        tick();
    endtask

    task automatic test_rr_reads();
        logic [3:0] exp_acc;
        do_reset();
        mcmd_valid = 4'hF;
        for (int i = 0; i < N; i++) mcmd[i*CW +: CW] = 16'hA0 + 16'(i);
        for (int k = 0; k < 5; k++) begin
            exp_acc = 4'b0001 << (k % 4);
            #1;
            checks++;
            if (o_scmd_accept !== exp_acc) begin
                failures++; $display("FAIL rr_accept k=%0d got=%b exp=%b", k, o_scmd_accept, exp_acc);
            end
            @(posedge i_clk);
            #1;
            checks++;
            if (o_mcmd_valid !== 1'b1 || o_grant_id !== 2'(k % 4) || o_mcmd !== 16'hA0 + 16'(k % 4)) begin
                failures++;
                $display("FAIL rr_mcmd k=%0d got=%b/%0d/%h exp=1/%0d/%h", k, o_mcmd_valid, o_grant_id, o_mcmd, k % 4, 16'hA0 + 16'(k % 4));
            end
            @(negedge i_clk);
        end
    endtask

    task automatic test_write_order();
        int b1 = 0;
        int b2 = 0;
        bit acc1 = 0;
        bit acc2 = 0;
        logic [DW-1:0] got_d[$];
        bit got_l[$];
        logic [DW-1:0] exp_d[6] = '{16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h2000, 16'h2001};
        do_reset();
        for (int c = 0; c < 20; c++) begin
            mcmd_valid[1] = !acc1; is_write[1] = 1'b1; mcmd[1*CW +: CW] = 16'h0111;
            mcmd_valid[2] = !acc2; is_write[2] = 1'b1; mcmd[2*CW +: CW] = 16'h0222;
            mdata_valid[1] = (b1 < 4); mdata[1*DW +: DW] = 16'h1000 + 16'(b1); mdata_last[1] = (b1 == 3);
            mdata_valid[2] = (b2 < 2); mdata[2*DW +: DW] = 16'h2000 + 16'(b2); mdata_last[2] = (b2 == 1);
            #1;
            if (c == 0) begin
                checks++;
                if (o_mdata_valid !== 1'b0) begin failures++; $display("FAIL wr_data_before_cmd got=%b exp=0", o_mdata_valid); end
            end
            if (o_mdata_valid && sdata_accept) begin
                got_d.push_back(o_mdata);
                got_l.push_back(o_mdata_last);
            end
            if (o_scmd_accept[1]) acc1 = 1;
            if (o_scmd_accept[2]) acc2 = 1;
            if (o_sdata_accept[1] && mdata_valid[1]) b1++;
            if (o_sdata_accept[2] && mdata_valid[2]) b2++;
            tick();
        end
        checks++;
        if (got_d.size() != 6) begin
            failures++; $display("FAIL wr_beat_count got=%0d exp=6", got_d.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (got_d[k] !== exp_d[k] || got_l[k] !== (k == 3 || k == 5)) begin
                    failures++; $display("FAIL wr_beat k=%0d got=%h/%b exp=%h/%b", k, got_d[k], got_l[k], exp_d[k], (k == 3 || k == 5));
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_fifo_full();
        logic [3:0] exp_acc[6] = '{4'b0001, 4'b0010, 4'b1000, 4'b0000, 4'b0000, 4'b0100};
        logic [3:0] pend;
        do_reset();
        pend     = 4'hF;
        is_write = 4'b0111;
        for (int i = 0; i < N; i++) mcmd[i*CW +: CW] = 16'hF0 + 16'(i);
        for (int c = 0; c < 6; c++) begin
            mcmd_valid     = pend;
            mdata_valid[0] = (c == 5);
            mdata_last[0]  = 1'b1;
            #1;
            checks++;
            if (o_scmd_accept !== exp_acc[c]) begin
                failures++; $display("FAIL full_accept c=%0d got=%b exp=%b", c, o_scmd_accept, exp_acc[c]);
            end
            if (c == 3) begin
                checks++;
                if (o_grant_id !== 2'd3) begin failures++; $display("FAIL full_read_id got=%0d exp=3", o_grant_id); end
            end
            if (c == 5) begin
                checks++;
                if (o_sdata_accept !== 4'b0001 || o_mdata_valid !== 1'b1) begin
                    failures++; $display("FAIL full_pop got=%b/%b exp=0001/1", o_sdata_accept, o_mdata_valid);
                end
            end
            pend = pend & ~o_scmd_accept;
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_hold();
        do_reset();
        scmd_accept       = 1'b0;
        mcmd_valid        = 4'b0100;
        mcmd[2*CW +: CW]  = 16'hC2;
        #1;
        checks++;
        if (o_scmd_accept !== 4'b0100) begin failures++; $display("FAIL hold_first got=%b exp=0100", o_scmd_accept); end
        tick();
        mcmd_valid = 4'b1011;
        mcmd[0*CW +: CW] = 16'hC0; mcmd[1*CW +: CW] = 16'hC1; mcmd[3*CW +: CW] = 16'hC3;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (o_scmd_accept !== '0 || o_mcmd_valid !== 1'b1 || o_mcmd !== 16'hC2 || o_grant_id !== 2'd2) begin
                failures++;
                $display("FAIL hold c=%0d got=%b/%b/%h/%0d exp=0000/1/00c2/2", c, o_scmd_accept, o_mcmd_valid, o_mcmd, o_grant_id);
            end
            tick();
        end
        scmd_accept = 1'b1;
        #1;
        checks++;
        if (o_scmd_accept !== 4'b1000) begin failures++; $display("FAIL hold_release got=%b exp=1000", o_scmd_accept); end
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        mcmd_valid = 4'b0010; is_write = 4'b0010; mcmd[1*CW +: CW] = 16'hB1;
        mdata_valid = 4'b0010; mdata[1*DW +: DW] = 16'h5000;
        #1;
        checks++;
        if (o_mdata_valid !== 1'b0) begin failures++; $display("FAIL midrst_early_data got=%b exp=0", o_mdata_valid); end
        tick();
        mcmd_valid = '0;
        for (int b = 0; b < 2; b++) begin
            #1;
            checks++;
            if (o_mdata_valid !== 1'b1 || o_sdata_accept !== 4'b0010) begin
                failures++; $display("FAIL midrst_beat b=%0d got=%b/%b exp=1/0010", b, o_mdata_valid, o_sdata_accept);
            end
            tick();
        end
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        mcmd_valid = 4'hF; is_write = '0;
        #1;
        checks++;
        if (o_mcmd_valid !== 1'b0 || o_mdata_valid !== 1'b0 || o_sdata_accept !== '0) begin
            failures++; $display("FAIL midrst_after got=%b/%b/%b exp=0/0/0000", o_mcmd_valid, o_mdata_valid, o_sdata_accept);
        end
        checks++;
        if (o_scmd_accept !== 4'b0001) begin failures++; $display("FAIL midrst_grant got=%b exp=0001", o_scmd_accept); end
        tick();
        clear_inputs();
    endtask

`ifdef PZCOREBUS_REQUEST_ARBITER_URGENT_EN
    task automatic test_urgent();
        logic [3:0] pend;
        logic [3:0] exp_acc[2] = '{4'b0100, 4'b0001};
        do_reset();
        pend   = 4'b0101;
        urgent = 4'b0100;
        for (int c = 0; c < 2; c++) begin
            mcmd_valid = pend;
            #1;
            checks++;
            if (o_scmd_accept !== exp_acc[c]) begin
                failures++; $display("FAIL urgent c=%0d got=%b exp=%b", c, o_scmd_accept, exp_acc[c]);
            end
            pend = pend & ~o_scmd_accept;
            tick();
        end
        clear_inputs();
    endtask
`endif

    task automatic test_random();
        bit            pend[N];
        logic [CW-1:0] pend_cmd[N];
        bit            pend_wr[N];
        int            pend_len[N];
        int            bq[N][$];
        int            beat[N];
        bit            m_valid;
        logic [CW-1:0] m_cmd;
        int            m_id;
        int            m_rr;
        int            m_fifo[$];
        int            h;
        int            g;
        bit            exp_dvalid;
        bit            dhs;
        bit            pop;
        bit            open;
        bit            wok;
        logic [N-1:0]  elig;
        logic [N-1:0]  urg;
        logic [N-1:0]  exp_acc;
        logic [N-1:0]  exp_dacc;

        do_reset();
        m_valid = 0; m_cmd = '0; m_id = 0; m_rr = 0;
        for (int i = 0; i < N; i++) begin pend[i] = 0; beat[i] = 0; pend_cmd[i] = '0; pend_wr[i] = 0; pend_len[i] = 1; end

        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i]     = 1;
                    pend_cmd[i] = 16'($urandom);
                    pend_wr[i]  = 1'($urandom_range(0, 1));
                    pend_len[i] = $urandom_range(1, 4);
                end
                mcmd_valid[i]      = pend[i];
                mcmd[i*CW +: CW]   = pend_cmd[i];
                is_write[i]        = pend_wr[i];
                mdata[i*DW +: DW]  = 16'($urandom);
                if (bq[i].size() > 0) begin
                    mdata_valid[i] = ($urandom_range(0, 3) != 0);
                    mdata_last[i]  = (beat[i] == bq[i][0] - 1);
                end else begin
                    mdata_valid[i] = 1'($urandom_range(0, 1));
                    mdata_last[i]  = 1'($urandom_range(0, 1));
                end
            end
`ifdef PZCOREBUS_REQUEST_ARBITER_URGENT_EN
            urgent = 4'($urandom);
`endif
            scmd_accept  = ($urandom_range(0, 3) != 0);
            sdata_accept = ($urandom_range(0, 3) != 0);
            #1;

            urg = '0;
`ifdef PZCOREBUS_REQUEST_ARBITER_URGENT_EN
            urg = urgent;
`endif
            h          = (m_fifo.size() > 0) ? m_fifo[0] : -1;
            exp_dvalid = (h >= 0) && mdata_valid[h];
            dhs        = exp_dvalid && sdata_accept;
            pop        = dhs && mdata_last[h];
            open       = !m_valid || scmd_accept;
            wok        = (m_fifo.size() < DEPTH) || pop;
            for (int i = 0; i < N; i++) elig[i] = mcmd_valid[i] && (!is_write[i] || wok);
            g        = open ? model_pick(elig, urg, m_rr) : -1;
            exp_acc  = (g >= 0) ? (4'b0001 << g) : 4'b0000;
            exp_dacc = (h >= 0 && sdata_accept) ? (4'b0001 << h) : 4'b0000;

            checks++;
            if (o_scmd_accept !== exp_acc) begin
                failures++; $display("FAIL rnd_cmd_accept cyc=%0d got=%b exp=%b", cyc, o_scmd_accept, exp_acc);
            end
            checks++;
            if (o_mcmd_valid !== m_valid) begin
                failures++; $display("FAIL rnd_mcmd_valid cyc=%0d got=%b exp=%b", cyc, o_mcmd_valid, m_valid);
            end else if (m_valid) begin
                checks++;
                if (o_mcmd !== m_cmd || o_grant_id !== 2'(m_id)) begin
                    failures++; $display("FAIL rnd_mcmd cyc=%0d got=%h/%0d exp=%h/%0d", cyc, o_mcmd, o_grant_id, m_cmd, m_id);
                end
            end
            checks++;
            if (o_mdata_valid !== exp_dvalid || o_sdata_accept !== exp_dacc) begin
                failures++;
                $display("FAIL rnd_data_ctl cyc=%0d got=%b/%b exp=%b/%b", cyc, o_mdata_valid, o_sdata_accept, exp_dvalid, exp_dacc);
            end else if (exp_dvalid) begin
                checks++;
                if (o_mdata !== mdata[h*DW +: DW] || o_mdata_last !== mdata_last[h]) begin
                    failures++;
                    $display("FAIL rnd_data cyc=%0d got=%h/%b exp=%h/%b", cyc, o_mdata, o_mdata_last, mdata[h*DW +: DW], mdata_last[h]);
                end
            end

            @(posedge i_clk);
            if (dhs) begin
                if (mdata_last[h]) begin
                    void'(bq[h].pop_front());
                    beat[h] = 0;
                end else begin
                    beat[h]++;
                end
            end
            if (pop) void'(m_fifo.pop_front());
            if (g >= 0) begin
                pend[g] = 0;
                if (pend_wr[g]) begin
                    m_fifo.push_back(g);
                    bq[g].push_back(pend_len[g]);
                end
            end
            if (open) begin
                m_valid = (g >= 0);
                if (g >= 0) begin
                    m_cmd = pend_cmd[g];
                    m_id  = g;
                    m_rr  = (g + 1) % N;
                end
            end
            @(negedge i_clk);
        end
        clear_inputs();
    endtask

    initial begin
        i_rst = 1'b1;
        clear_inputs();
        @(negedge i_clk);
        test_reset();
        test_rr_reads();
        test_write_order();
        test_fifo_full();
        test_hold();
        test_reset_mid_burst();
`ifdef PZCOREBUS_REQUEST_ARBITER_URGENT_EN
        test_urgent();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
